// File: rtl/vdp_host_interface_fifo_if.sv
// ---------------------------------------------------------------------------
// vdp_host_interface_fifo_if
//
// Bundles every non-clock signal of the VDP host interface FIFO so that the
// block and its environment share one definition.
//
//   CPU side      : host_address, host_write_en, host_write_data,
//                   host_read_en  -> block;  ready <- block
//   Copper side   : cop_write_en, cop_write_address, cop_write_data -> block
//   VRAM status   : vram_write_pending -> block
//   Register port : register_write_en/address/data, read_address <- block
//   Status        : fifo_level, preempt_count, read_state_dbg <- block
//
// Handshake semantics (the one place they are written down):
//   host_write_en / host_read_en act as "valid" and are held by the CPU
//   until it sees ready=1 for one cycle, after which the CPU drops the
//   strobe for at least one clock edge before starting another transfer.
//   A write is taken on the edge where valid is high, the strobe has not
//   already been taken, and the FIFO has room; ready follows one cycle later.
//   A read is acknowledged two edges after it is allowed to start.
//   cop_write_en is a single-cycle strobe with no backpressure at all.
//   Write and read strobes are never raised together by the CPU.
// ---------------------------------------------------------------------------
interface vdp_host_interface_fifo_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] host_address;
  logic                  host_write_en;
  logic [DATA_WIDTH-1:0] host_write_data;
  logic                  host_read_en;
  logic                  ready;

  logic                  cop_write_en;
  logic [ADDR_WIDTH-1:0] cop_write_address;
  logic [DATA_WIDTH-1:0] cop_write_data;

  logic                  vram_write_pending;

  logic                  register_write_en;
  logic [ADDR_WIDTH-1:0] register_write_address;
  logic [DATA_WIDTH-1:0] register_write_data;
  logic [ADDR_WIDTH-1:0] read_address;

  logic [LVL_W-1:0]      fifo_level;
  logic [CNT_WIDTH-1:0]  preempt_count;
  // 1 while the read handshake is in its acknowledge (WAIT) state
  logic                  read_state_dbg;

  // Environment driving the block (CPU, copper, VRAM controller)
  modport master (
    output host_address, host_write_en, host_write_data, host_read_en,
    output cop_write_en, cop_write_address, cop_write_data,
    output vram_write_pending,
    input  ready,
    input  register_write_en, register_write_address, register_write_data,
    input  read_address, fifo_level, preempt_count, read_state_dbg
  );

  // The FIFO block itself
  modport slave (
    input  host_address, host_write_en, host_write_data, host_read_en,
    input  cop_write_en, cop_write_address, cop_write_data,
    input  vram_write_pending,
    output ready,
    output register_write_en, register_write_address, register_write_data,
    output read_address, fifo_level, preempt_count, read_state_dbg
  );
endinterface

// File: rtl/vdp_host_interface_fifo.sv
// ---------------------------------------------------------------------------
// vdp_host_interface_fifo
//
// Merges CPU and copper register writes onto the single VDP register write
// port. CPU writes are buffered in a FIFO_DEPTH-entry FIFO so the CPU only
// stalls when the FIFO is full; copper writes always win the port and are
// forwarded one cycle after their strobe. CPU reads are held off until every
// buffered CPU write has reached the register file, which keeps reads
// ordered after earlier writes.
//
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-high; clears FIFO, handshake state,
//            preemption counter and every output
//   bus    - slave modport of vdp_host_interface_fifo_if carrying the CPU,
//            copper, VRAM-status, register-port and status signals
// ---------------------------------------------------------------------------
module vdp_host_interface_fifo #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  vdp_host_interface_fifo_if.slave    bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_WAIT = 1'b1
  } rd_state_e;

  // FIFO storage and bookkeeping
  logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;

  // CPU handshake state
  logic                  write_pending_q, write_pending_d;
  logic                  read_pending_q, read_pending_d;
  logic                  ready_q, ready_d;
  rd_state_e             rd_state_q, rd_state_d;

  // Registered register-file port
  logic                  reg_we_q, reg_we_d;
  logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_WIDTH-1:0] reg_data_q, reg_data_d;
  logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;

  logic [CNT_WIDTH-1:0]  preempt_q, preempt_d;

  // Per-cycle decisions
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;
  logic                  rd_start;
  logic [ENT_W-1:0]      head;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  // -------------------------------------------------------------------------
  // Push / pop decisions. A full FIFO refuses the push even when a pop frees
  // a slot in the same cycle; this keeps the full flag a pure function of
  // the registered level. write_pending stops a held strobe from being
  // taken twice.
  // -------------------------------------------------------------------------
  always_comb begin
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == DEPTH_LVL);
    push       = bus.host_write_en && !write_pending_q && !fifo_full;
    // Copper owns the port this cycle, or VRAM is mid-write: hold the queue
    pop        = !fifo_empty && !bus.cop_write_en && !bus.vram_write_pending;
    head       = mem_q[rd_ptr_q];
    head_addr  = head[ENT_W-1:DATA_WIDTH];
    head_data  = head[DATA_WIDTH-1:0];
  end

  // -------------------------------------------------------------------------
  // FIFO storage, pointers (wrap naturally, depth is a power of two) and
  // occupancy.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (push) begin
      mem_d[wr_ptr_q] = {bus.host_address, bus.host_write_data};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // -------------------------------------------------------------------------
  // Register port: copper first, then FIFO head, otherwise the strobe drops
  // and address/data keep their last values.
  // -------------------------------------------------------------------------
  always_comb begin
    reg_we_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_data_d  = reg_data_q;
    read_addr_d = bus.host_address;
    preempt_d   = preempt_q;

    if (bus.cop_write_en) begin
      reg_we_d   = 1'b1;
      reg_addr_d = bus.cop_write_address;
      reg_data_d = bus.cop_write_data;
    end else if (pop) begin
      reg_we_d   = 1'b1;
      reg_addr_d = head_addr;
      reg_data_d = head_data;
    end

    // Counts only cycles where the copper actually delayed buffered work
    if (bus.cop_write_en && !fifo_empty && !(&preempt_q)) begin
      preempt_d = preempt_q + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Read handshake FSM. A read may only start when nothing is buffered and
  // no write is on the register port (reg_we_q covers the last popped
  // entry still in flight). A simultaneous write strobe takes priority.
  // -------------------------------------------------------------------------
  always_comb begin
    rd_state_d = rd_state_q;
    rd_start   = 1'b0;

    case (rd_state_q)
      RD_IDLE: begin
        if (bus.host_read_en && !bus.host_write_en && !read_pending_q &&
            fifo_empty && !reg_we_q) begin
          rd_state_d = RD_WAIT;
          rd_start   = 1'b1;
        end
      end
      RD_WAIT: begin
        rd_state_d = RD_IDLE;
      end
      default: begin
        rd_state_d = RD_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Strobe-taken flags and the shared acknowledge.
  // -------------------------------------------------------------------------
  always_comb begin
    write_pending_d = write_pending_q;
    read_pending_d  = read_pending_q;

    if (push) begin
      write_pending_d = 1'b1;
    end else if (!bus.host_write_en) begin
      write_pending_d = 1'b0;
    end

    if (rd_start) begin
      read_pending_d = 1'b1;
    end else if (!bus.host_read_en) begin
      read_pending_d = 1'b0;
    end

    // Write acknowledge the cycle after the push; read acknowledge as the
    // FSM leaves WAIT.
    ready_d = push || (rd_state_q == RD_WAIT);
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q           <= '{default: '0};
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      level_q         <= '0;
      write_pending_q <= 1'b0;
      read_pending_q  <= 1'b0;
      ready_q         <= 1'b0;
      rd_state_q      <= RD_IDLE;
      reg_we_q        <= 1'b0;
      reg_addr_q      <= '0;
      reg_data_q      <= '0;
      read_addr_q     <= '0;
      preempt_q       <= '0;
    end else begin
      mem_q           <= mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      level_q         <= level_d;
      write_pending_q <= write_pending_d;
      read_pending_q  <= read_pending_d;
      ready_q         <= ready_d;
      rd_state_q      <= rd_state_d;
      reg_we_q        <= reg_we_d;
      reg_addr_q      <= reg_addr_d;
      reg_data_q      <= reg_data_d;
      read_addr_q     <= read_addr_d;
      preempt_q       <= preempt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.ready                  = ready_q;
  assign bus.register_write_en      = reg_we_q;
  assign bus.register_write_address = reg_addr_q;
  assign bus.register_write_data    = reg_data_q;
  assign bus.read_address           = read_addr_q;
  assign bus.fifo_level             = level_q;
  assign bus.preempt_count          = preempt_q;
  assign bus.read_state_dbg         = (rd_state_q == RD_WAIT);

  // The CPU never overlaps write and read strobes; catch it if it does.
  a_no_push_during_read: assert property (
    @(posedge clk) disable iff (reset) !(push && bus.host_read_en)
  );

endmodule

// File: tb/tb_vdp_host_interface_fifo.sv
module tb_vdp_host_interface_fifo;
  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 2;
  localparam int ENT_W = AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vdp_host_interface_fifo_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                               .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) vif ();

  vdp_host_interface_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                            .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  int vectors = 0;
  int errors  = 0;
  bit cpu_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // exp_q holds the CPU writes the register file has still to receive.
  logic [ENT_W-1:0] exp_q[$];
  bit               m_wp = 0, m_rp = 0, m_ack_due = 0, m_ready = 0, m_we = 0;
  logic [AW-1:0]    m_wa = '0, m_ra = '0;
  logic [DW-1:0]    m_wd = '0;
  logic [CW-1:0]    m_pc = '0;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        exp_q.delete();
        m_wp = 0; m_rp = 0; m_ack_due = 0; m_ready = 0; m_we = 0;
        m_wa = '0; m_wd = '0; m_ra = '0; m_pc = '0;
      end else begin
        int occ;
        bit push, pop, rd_go;
        logic [ENT_W-1:0] head;
        occ   = exp_q.size();
        push  = vif.host_write_en && !m_wp && occ < DEPTH;
        pop   = occ > 0 && !vif.cop_write_en && !vif.vram_write_pending;
        rd_go = !m_ack_due && vif.host_read_en && !vif.host_write_en && !m_rp &&
                occ == 0 && !m_we;
        m_ready   = push || m_ack_due;
        m_ack_due = rd_go;
        if (vif.cop_write_en && occ > 0 && m_pc != '1) m_pc = m_pc + 1'b1;
        if (vif.cop_write_en) begin
          m_we = 1; m_wa = vif.cop_write_address; m_wd = vif.cop_write_data;
        end else if (pop) begin
          head = exp_q.pop_front();
          m_we = 1; m_wa = head[ENT_W-1:DW]; m_wd = head[DW-1:0];
        end else begin
          m_we = 0;
        end
        if (push) exp_q.push_back({vif.host_address, vif.host_write_data});
        m_wp = push ? 1'b1 : (vif.host_write_en ? m_wp : 1'b0);
        m_rp = rd_go ? 1'b1 : (vif.host_read_en ? m_rp : 1'b0);
        m_ra = vif.host_address;
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("ready", vif.ready, m_ready);
      chk("reg_we", vif.register_write_en, m_we);
      if (m_we) begin
        chk("reg_addr", vif.register_write_address, m_wa);
        chk("reg_data", vif.register_write_data, m_wd);
      end
      chk("read_address", vif.read_address, m_ra);
      chk("fifo_level", vif.fifo_level, exp_q.size());
      chk("preempt_count", vif.preempt_count, m_pc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    vif.host_write_en = 0; vif.host_read_en = 0;
    vif.cop_write_en = 0; vif.vram_write_pending = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int t = 0;
    vif.host_address = a; vif.host_write_data = d; vif.host_write_en = 1'b1;
    do begin @(posedge clk); #1; t++; end while (!vif.ready && t < 300);
    chk("write_ack", vif.ready, 1);
    vif.host_write_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic cpu_read(input logic [AW-1:0] a);
    int t = 0;
    vif.host_address = a; vif.host_read_en = 1'b1;
    do begin @(posedge clk); #1; t++; end while (!vif.ready && t < 300);
    chk("read_ack", vif.ready, 1);
    vif.host_read_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((vif.fifo_level != 0 || vif.register_write_en) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk("drain_level", vif.fifo_level, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vif.host_address = '0; vif.host_write_data = '0; vif.host_write_en = 0;
    vif.host_read_en = 0; vif.cop_write_en = 0; vif.cop_write_address = '0;
    vif.cop_write_data = '0; vif.vram_write_pending = 0;
    reset = 1'b1;
    #2;
    chk("reset_we", vif.register_write_en, 0);
    chk("reset_level", vif.fifo_level, 0);
    reset_dut();

    // Single CPU write
    vif.host_address = 5'h03; vif.host_write_data = 16'hA5A5; vif.host_write_en = 1;
    @(posedge clk); #1;
    chk("single_ready", vif.ready, 1);
    vif.host_write_en = 0;
    @(posedge clk); #1;
    chk("single_we", vif.register_write_en, 1);
    chk("single_addr", vif.register_write_address, 5'h03);
    chk("single_data", vif.register_write_data, 16'hA5A5);
    chk("single_ready_low", vif.ready, 0);
    chk("single_level", vif.fifo_level, 0);
    @(posedge clk); #1;
    chk("single_we_low", vif.register_write_en, 0);

    // Six writes against a blocked drain
    reset_dut();
    vif.vram_write_pending = 1;
    fork
      begin
        for (int i = 0; i < 6; i++) cpu_write(AW'(i + 1), 16'h1000 + 16'(i));
      end
      begin
        repeat (8) @(posedge clk);
        for (int k = 0; k < 6; k++) begin
          @(posedge clk); #1;
          chk("full_stall_ready", vif.ready, 0);
        end
        chk("full_level", vif.fifo_level, 4);
        vif.vram_write_pending = 0;
      end
    join
    wait_drain();

    // Copper preempting a two-entry FIFO
    reset_dut();
    vif.vram_write_pending = 1;
    cpu_write(5'h04, 16'h1111);
    cpu_write(5'h05, 16'h2222);
    chk("cop_pre_level", vif.fifo_level, 2);
    for (int i = 0; i < 3; i++) begin
      vif.cop_write_en = 1; vif.cop_write_address = AW'(16 + i);
      vif.cop_write_data = 16'hC000 + 16'(i); vif.vram_write_pending = 0;
      @(posedge clk); #1;
      chk("cop_we", vif.register_write_en, 1);
      chk("cop_addr", vif.register_write_address, 16 + i);
      chk("cop_data", vif.register_write_data, 16'hC000 + 16'(i));
    end
    vif.cop_write_en = 0;
    @(posedge clk); #1;
    chk("resume_a_addr", vif.register_write_address, 5'h04);
    chk("resume_a_data", vif.register_write_data, 16'h1111);
    @(posedge clk); #1;
    chk("resume_b_addr", vif.register_write_address, 5'h05);
    chk("resume_b_data", vif.register_write_data, 16'h2222);
    chk("resume_level", vif.fifo_level, 0);
    chk("preempt_3", vif.preempt_count, 3);

    // Read held behind two buffered writes
    reset_dut();
    vif.vram_write_pending = 1;
    cpu_write(5'h0A, 16'hAAAA);
    cpu_write(5'h0B, 16'hBBBB);
    vif.host_address = 5'h1B; vif.host_read_en = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("read_blocked", vif.ready, 0);
    end
    vif.vram_write_pending = 0;
    @(posedge clk); #1;
    chk("raw_a_we", vif.register_write_en, 1);
    chk("raw_a_addr", vif.register_write_address, 5'h0A);
    @(posedge clk); #1;
    chk("raw_b_addr", vif.register_write_address, 5'h0B);
    chk("raw_b_ready", vif.ready, 0);
    @(posedge clk); #1;
    chk("raw_we_low", vif.register_write_en, 0);
    chk("raw_ready_e3", vif.ready, 0);
    @(posedge clk); #1;
    chk("raw_ready_e4", vif.ready, 0);
    @(posedge clk); #1;
    chk("raw_ready_e5", vif.ready, 1);
    chk("raw_read_addr", vif.read_address, 5'h1B);
    vif.host_read_en = 0;
    @(posedge clk); #1;
    chk("raw_ready_off", vif.ready, 0);

    // Asynchronous reset mid-drain
    reset_dut();
    vif.vram_write_pending = 1;
    cpu_write(5'h11, 16'h0101);
    cpu_write(5'h12, 16'h0202);
    cpu_write(5'h13, 16'h0303);
    vif.vram_write_pending = 0;
    vif.host_address = 5'h1F;
    @(posedge clk); #1;
    chk("mid_drain_we", vif.register_write_en, 1);
    chk("mid_drain_level", vif.fifo_level, 2);
    #2 reset = 1'b1;
    #1;
    chk("arst_ready", vif.ready, 0);
    chk("arst_we", vif.register_write_en, 0);
    chk("arst_addr", vif.register_write_address, 0);
    chk("arst_data", vif.register_write_data, 0);
    chk("arst_read_addr", vif.read_address, 0);
    chk("arst_level", vif.fifo_level, 0);
    chk("arst_preempt", vif.preempt_count, 0);
    #2 reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("post_reset_we", vif.register_write_en, 0);
    end

    // Preempt counter saturation
    reset_dut();
    vif.vram_write_pending = 1;
    cpu_write(5'h07, 16'h7777);
    for (int k = 0; k < 5; k++) begin
      vif.cop_write_en = 1; vif.cop_write_address = 5'h1C; vif.cop_write_data = 16'(k);
      @(posedge clk); #1;
      chk("sat_count", vif.preempt_count, (k + 1 > 3) ? 3 : k + 1);
    end
    vif.cop_write_en = 0; vif.vram_write_pending = 0;
    wait_drain();
    chk("sat_hold", vif.preempt_count, 2'b11);

    // Randomised mix checked by the model
    reset_dut();
    cpu_done = 0;
    fork
      begin
        for (int n = 0; n < 80; n++) begin
          if ($urandom_range(0, 3) != 0) cpu_write(AW'($urandom), DW'($urandom));
          else cpu_read(AW'($urandom));
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        cpu_done = 1;
      end
      begin
        while (!cpu_done) begin
          vif.cop_write_en = ($urandom_range(0, 3) == 0);
          vif.cop_write_address = AW'($urandom);
          vif.cop_write_data = DW'($urandom);
          vif.vram_write_pending = ($urandom_range(0, 2) == 0);
          @(posedge clk); #1;
        end
        vif.cop_write_en = 0; vif.vram_write_pending = 0;
      end
    join
    wait_drain();
    repeat (2) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
